uart_bus_master: RTL
====================

// Module: uart_bus_master
// PURPOSE
//  Debug initiator for the peripheral bus: receives command frames as UART bytes and issues single
//  word reads/writes on the rd/wr/addr/wdata/rdata bus. Returns a response frame through a UART
//  transmitter byte handshake. Sits beside the CPU on the data bus, muxed in when `active`=1.
// PARAMETERS
//  TIMEOUT_CYCLES  1000000  max clk cycles between bytes of one frame before it is discarded
//  TIMEOUT_W       20       width of inter-byte timeout counter (must hold TIMEOUT_CYCLES)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-low reset
//  rx_data    in   8   received byte, valid when rx_valid=1
//  rx_valid   in   1   1-cycle strobe per received byte, synchronous to clk
//  tx_data    out  8   byte to transmit, stable while tx_en=1
//  tx_en      out  1   transmit request
//  tx_status  in   1   transmitter busy (uart clock domain; 2-flop synchronized internally)
//  bus_rd     out  1   bus read strobe
//  bus_wr     out  1   bus write strobe
//  bus_addr   out  32  bus address
//  bus_wdata  out  32  bus write data
//  bus_rdata  in   32  bus read data (combinational from slave, valid in same cycle as bus_rd)
//  active     out  1   1 whenever FSM is not IDLE
//  err        out  1   1-cycle pulse: timeout, unknown command, overrun, checksum fail
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; timeout counter=0; sync flops=0.
//  Frames (multi-byte fields MSB first):
//   write: 0x57 'W', A3..A0, D3..D0 -> bus write, response 0x4B 'K'
//   read:  0x52 'R', A3..A0         -> bus read,  response R3..R0
//   other first byte                -> response 0x3F '?', err pulse
//  bus_addr = {A[31:2],2'b00}: low two address bits forced to zero.
//  FSM: IDLE -> ADDR (4 bytes) -> [DATA (4 bytes, write only)] -> BUS -> RESP -> IDLE.
//   Unknown command goes IDLE -> RESP directly.
//  BUS: exactly one cycle; bus_rd or bus_wr =1 for that cycle only, never both.
//   Read: bus_rdata is latched in that same cycle.
//   Exactly one strobe per frame, so read side effects (e.g. clear-on-read) fire exactly once.
//  bus_addr/bus_wdata hold last values outside BUS; strobes are 0 outside BUS.
//  RESP, per byte:
//   - drive tx_data and set tx_en=1;
//   - when synchronized tx_status=1, clear tx_en;
//   - wait for synchronized tx_status=0 before the next byte.
//   After the last byte returns to tx_status=0, go to IDLE.
//  Timeout:
//   - Counter cleared on every rx_valid; counts only in ADDR/DATA.
//   - On reaching TIMEOUT_CYCLES: frame discarded, no bus access, no response, err pulse, -> IDLE.
//  Overrun: rx_valid during BUS/RESP drops that byte and pulses err; the frame in progress completes.
//  rx_valid is ignored in the cycle FSM leaves RESP (next frame starts only from IDLE).
//  Reset mid-frame: immediate abort; tx_en and strobes low asynchronously.
//  Byte counters are 2-bit, wrap 3->0 on field completion.
// CONFIGURATION
//  UART_BUS_MASTER_CSUM_EN defined:
//   - each command frame carries a trailing byte = XOR of all preceding frame bytes (CSUM state before BUS);
//   - mismatch -> no bus access, response 0x45 'E', err pulse;
//   - read response appends XOR of R3..R0 as a 5th byte.
//  Not defined: no checksum byte in either direction; CSUM state absent.
// TESTING
//  1. W,40,00,00,0C,00,00,00,A5 -> one bus_wr cycle, addr 0x4000000C, wdata 0x000000A5; tx 0x4B
//  2. R,40,00,00,10 with bus_rdata=0x0000003C -> one bus_rd cycle; tx 00,00,00,3C in order, one per tx handshake
//  3. 0x00 command -> tx 0x3F, err pulse, no bus strobe; next valid frame executes normally
//  4. R,40,00 then silence TIMEOUT_CYCLES -> err pulse, IDLE, no strobe/tx; next frame OK
//  5. Extra byte during RESP -> err pulse, response completes unchanged; reset asserted mid-DATA -> all outputs 0, IDLE
//  6. CSUM_EN: W frame with bad XOR -> tx 0x45, no bus_wr; good R frame -> 5 bytes, last = XOR of data

Source files
------------

// File: rtl/uart_bus_master.sv
// UART debug bus master: turns W/R command frames into single-word bus accesses and replies over UART.
// Define UART_BUS_MASTER_CSUM_EN to add a trailing XOR checksum to command frames and read responses.
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_status,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        active,
    output logic        err
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] BYTE_ACK  = 8'h4B;
    localparam logic [7:0] BYTE_UNK  = 8'h3F;
    localparam logic [7:0] BYTE_ERR  = 8'h45;

`ifdef UART_BUS_MASTER_CSUM_EN
    typedef enum logic [2:0] {IDLE, ADDR, DATA, CSUM, BUS, RESP} state_t;
    localparam state_t     FRAME_END   = CSUM;
    localparam logic [2:0] READ_LEN_M1 = 3'd4;
`else
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
    localparam state_t     FRAME_END   = BUS;
    localparam logic [2:0] READ_LEN_M1 = 3'd3;
`endif

    typedef enum logic [1:0] {RESP_ACK, RESP_READ, RESP_UNK, RESP_ERR} resp_t;

    state_t                 state;
    state_t                 state_next;
    resp_t                  resp_kind;
    logic [1:0]             byte_cnt;
    logic                   is_write;
    logic [31:0]            addr_reg;
    logic [31:0]            data_reg;
    logic [31:0]            addr_full;
    logic [31:0]            data_full;
    logic [31:0]            rdata_reg;
    logic [2:0]             resp_idx;
    logic [2:0]             resp_len_m1;
    logic                   resp_last;
    logic                   tx_wait;
    logic                   status_meta;
    logic                   status_sync;
    logic [TIMEOUT_W-1:0]   timeout_cnt;
    logic                   counting;
    logic                   timeout_hit;
    logic                   field_done;
    logic                   err_next;
`ifdef UART_BUS_MASTER_CSUM_EN
    logic [7:0]             csum_acc;
    logic [7:0]             rdata_xor;

    assign rdata_xor = rdata_reg[31:24] ^ rdata_reg[23:16] ^ rdata_reg[15:8] ^ rdata_reg[7:0];
    assign counting  = (state == ADDR) || (state == DATA) || (state == CSUM);
`else
    assign counting  = (state == ADDR) || (state == DATA);
`endif

    // The byte arriving this cycle completes the field, so the full word is visible one cycle early.
    assign addr_full   = (state == ADDR) ? {addr_reg[23:0], rx_data} : addr_reg;
    assign data_full   = (state == DATA) ? {data_reg[23:0], rx_data} : data_reg;
    assign field_done  = rx_valid && (byte_cnt == 2'd3);
    assign timeout_hit = counting && !rx_valid
                         && (timeout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign resp_len_m1 = (resp_kind == RESP_READ) ? READ_LEN_M1 : 3'd0;
    assign resp_last   = (resp_idx == resp_len_m1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        bus_rd     = 1'b0;
        bus_wr     = 1'b0;
        tx_en      = 1'b0;
        active     = (state != IDLE);
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
                        state_next = ADDR;
                    end else begin
                        state_next = RESP;
                        err_next   = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else if (field_done) begin
                    state_next = is_write ? DATA : FRAME_END;
                end
            end
            DATA: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else if (field_done) begin
                    state_next = FRAME_END;
                end
            end
`ifdef UART_BUS_MASTER_CSUM_EN
            CSUM: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else if (rx_valid) begin
                    if (rx_data == csum_acc) begin
                        state_next = BUS;
                    end else begin
                        state_next = RESP;
                        err_next   = 1'b1;
                    end
                end
            end
`endif
            BUS: begin
                bus_rd     = !is_write;
                bus_wr     = is_write;
                err_next   = rx_valid;
                state_next = RESP;
            end
            RESP: begin
                tx_en    = !tx_wait;
                err_next = rx_valid;
                if (tx_wait && !status_sync && resp_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt    <= '0;
            is_write    <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
            rdata_reg   <= '0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            resp_kind   <= RESP_ACK;
            resp_idx    <= '0;
            tx_wait     <= 1'b0;
            status_meta <= 1'b0;
            status_sync <= 1'b0;
            timeout_cnt <= '0;
            err         <= 1'b0;
`ifdef UART_BUS_MASTER_CSUM_EN
            csum_acc    <= '0;
`endif
        end else begin
            status_meta <= tx_status;
            status_sync <= status_meta;
            err         <= err_next;
            if (rx_valid || !counting) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
            // Bus address/data only change on the way into BUS so they hold between accesses.
            if (state_next == BUS) begin
                bus_addr <= addr_full & 32'hFFFF_FFFC;
                if (is_write) begin
                    bus_wdata <= data_full;
                end
            end
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        is_write  <= (rx_data == CMD_WRITE);
                        byte_cnt  <= '0;
                        resp_idx  <= '0;
                        tx_wait   <= 1'b0;
                        resp_kind <= RESP_UNK;
`ifdef UART_BUS_MASTER_CSUM_EN
                        csum_acc  <= rx_data;
`endif
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        addr_reg <= addr_full;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef UART_BUS_MASTER_CSUM_EN
                        csum_acc <= csum_acc ^ rx_data;
`endif
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        data_reg <= data_full;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef UART_BUS_MASTER_CSUM_EN
                        csum_acc <= csum_acc ^ rx_data;
`endif
                    end
                end
`ifdef UART_BUS_MASTER_CSUM_EN
                CSUM: begin
                    if (rx_valid && (rx_data != csum_acc)) begin
                        resp_kind <= RESP_ERR;
                    end
                end
`endif
                BUS: begin
                    if (is_write) begin
                        resp_kind <= RESP_ACK;
                    end else begin
                        resp_kind <= RESP_READ;
                        rdata_reg <= bus_rdata;
                    end
                end
                RESP: begin
                    // Each byte: hold tx_en until the transmitter reports busy, then wait for it to drain.
                    if (!tx_wait) begin
                        if (status_sync) begin
                            tx_wait <= 1'b1;
                        end
                    end else if (!status_sync && !resp_last) begin
                        resp_idx <= resp_idx + 3'd1;
                        tx_wait  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_data = 8'h00;
        if (state == RESP) begin
            case (resp_kind)
                RESP_ACK: tx_data = BYTE_ACK;
                RESP_UNK: tx_data = BYTE_UNK;
                RESP_ERR: tx_data = BYTE_ERR;
                default: begin
                    case (resp_idx)
                        3'd0:    tx_data = rdata_reg[31:24];
                        3'd1:    tx_data = rdata_reg[23:16];
                        3'd2:    tx_data = rdata_reg[15:8];
`ifdef UART_BUS_MASTER_CSUM_EN
                        3'd3:    tx_data = rdata_reg[7:0];
                        default: tx_data = rdata_xor;
`else
                        default: tx_data = rdata_reg[7:0];
`endif
                    endcase
                end
            endcase
        end
    end

endmodule
